// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: memory read request/done and decoder valid/ready handoff.
// master = fetch unit, slave = memory and decoder side.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 13
);
  logic              mem_read;
  logic              mem_instruction;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_done;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output mem_read,
    output mem_instruction,
    output mem_addr,
    input  mem_data,
    input  mem_done,
    output instr_out,
    output instr_valid,
    input  instr_ready,
    input  branch_taken,
    input  branch_target,
    output pc_out
  );

  modport slave (
    input  mem_read,
    input  mem_instruction,
    input  mem_addr,
    output mem_data,
    output mem_done,
    input  instr_out,
    input  instr_valid,
    output instr_ready,
    output branch_taken,
    output branch_target,
    input  pc_out
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads memory, hands words to the decoder.
// Optional memory timeout with sticky error: define FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 13,
  parameter int                DATA_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  output logic                     fetch_err,
  instruction_fetch_unit_if.master fetch_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] w_instr;
  logic              r_valid;
  logic              w_valid;
  logic              r_rd;
  logic              w_rd;
  logic              w_hs;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic             r_err;
  logic             w_err;
`else
  wire w_unused_max = (MAX_WAIT != 0);
`endif

  assign w_hs = r_valid & fetch_bus.instr_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_instr <= w_instr;
      r_valid <= w_valid;
      r_rd    <= w_rd;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_err <= w_err;
    end
  end
`endif

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_instr = r_instr;
    w_valid = r_valid;
    w_rd    = r_rd;
`ifdef FETCH_TIMEOUT_EN
    w_cnt   = r_cnt;
    w_err   = r_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state = S_REQ;
          w_rd    = 1'b1;
        end
      end
      S_REQ: begin
        w_state = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
        w_cnt   = '0;
`endif
      end
      S_WAIT: begin
        // a completion in the terminal-count cycle beats the timeout
        if (fetch_bus.mem_done) begin
          w_instr = fetch_bus.mem_data;
          w_valid = 1'b1;
          w_rd    = 1'b0;
          w_state = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (r_cnt == CNT_W'(MAX_WAIT - 1)) begin
          w_state = S_ERR;
          w_rd    = 1'b0;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (w_hs) begin
          w_valid = 1'b0;
          w_pc    = fetch_bus.branch_taken
                  ? fetch_bus.branch_target
                  : r_pc + 1'b1;
          if (run) begin
            w_state = S_REQ;
            w_rd    = 1'b1;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      S_ERR: begin
        w_state = S_ERR;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign fetch_bus.mem_read        = r_rd;
  assign fetch_bus.mem_instruction = r_rd;
  assign fetch_bus.mem_addr        = r_pc;
  assign fetch_bus.instr_out       = r_instr;
  assign fetch_bus.instr_valid     = r_valid;
  assign fetch_bus.pc_out          = r_pc;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = r_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random
// memory latency, stalls, branches and run gaps against a fetch model.
module tb_instruction_fetch_unit;
  localparam int AW = 13;
  localparam int DW = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic fetch_err;

  instruction_fetch_unit_if #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) bus_if ();

  instruction_fetch_unit #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .RESET_PC('0),
    .MAX_WAIT(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .fetch_err(fetch_err),
    .fetch_bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 idle/handed over, 1 fetch in flight, 2 word held
  int      phase = 0;
  int      cnt = 0;
  int      lat = 0;
  bit      done_sent = 1'b0;
  bit      last_run = 1'b0;
  bit      exp_err = 1'b0;
  logic [AW-1:0] exp_pc = '0;
  logic [DW-1:0] exp_word = '0;

  int k_run = -1;
  int k_ready = -1;
  int k_br = -1;
  int k_lat = -1;
  int k_data = -1;
  bit k_tgt_en = 1'b0;
  logic [AW-1:0] k_tgt = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [DW-1:0] d;
    bit            rdy;
    bit            br;
    logic [AW-1:0] tgt;
    @(negedge clk);
    chk("err", 32'(fetch_err), 32'(exp_err));
    if (phase == 1 && done_sent) phase = 2;
    bus_if.mem_done = 1'($urandom_range(0, 1));
    bus_if.mem_data = DW'($urandom);
    bus_if.instr_ready = 1'($urandom_range(0, 1));
    bus_if.branch_taken = 1'($urandom_range(0, 1));
    bus_if.branch_target = AW'($urandom);
    case (phase)
      0: begin
        chk("rd_idle", 32'(bus_if.mem_read), 32'(last_run));
        chk("vld_idle", 32'(bus_if.instr_valid), 0);
        if (last_run) begin
          chk("addr", 32'(bus_if.mem_addr), 32'(exp_pc));
          chk("minstr", 32'(bus_if.mem_instruction), 1);
          phase = 1;
          cnt = 0;
          done_sent = 1'b0;
          lat = (k_lat >= 0) ? k_lat : int'($urandom_range(0, 3));
        end
        bus_if.instr_ready = 1'b0;
      end
      1: begin
        chk("rd_busy", 32'(bus_if.mem_read), 1);
        chk("vld_busy", 32'(bus_if.instr_valid), 0);
        chk("pc_busy", 32'(bus_if.pc_out), 32'(exp_pc));
        bus_if.instr_ready = 1'b0;
        if (cnt == lat) begin
          d = (k_data >= 0) ? DW'(k_data) : DW'($urandom);
          bus_if.mem_done = 1'b1;
          bus_if.mem_data = d;
          exp_word = d;
          done_sent = 1'b1;
        end else begin
          bus_if.mem_done = 1'b0;
          cnt++;
        end
      end
      default: begin
        chk("vld_hold", 32'(bus_if.instr_valid), 1);
        chk("word", 32'(bus_if.instr_out), 32'(exp_word));
        chk("pc_hold", 32'(bus_if.pc_out), 32'(exp_pc));
        chk("rd_hold", 32'(bus_if.mem_read), 0);
        rdy = (k_ready >= 0) ? k_ready[0] : ($urandom_range(0, 2) != 0);
        br = (k_br >= 0) ? k_br[0] : 1'($urandom_range(0, 1));
        tgt = k_tgt_en ? k_tgt : AW'($urandom);
        bus_if.instr_ready = rdy;
        bus_if.branch_taken = br;
        bus_if.branch_target = tgt;
        if (rdy) begin
          exp_pc = br ? tgt : AW'(exp_pc + 1);
          phase = 0;
        end
      end
    endcase
    run = (k_run >= 0) ? k_run[0] : ($urandom_range(0, 7) != 0);
    last_run = run;
  endtask

  task automatic run_until(input int ph, input int maxc);
    for (int i = 0; i < maxc && phase != ph; i++) step();
    if (phase != ph) chk("bound", 0, 1);
  endtask

  task automatic do_reset(input bit r);
    #2 reset = 1'b0;
    #1;
    chk("rst_rd", 32'(bus_if.mem_read), 0);
    chk("rst_mi", 32'(bus_if.mem_instruction), 0);
    chk("rst_vld", 32'(bus_if.instr_valid), 0);
    chk("rst_word", 32'(bus_if.instr_out), 0);
    chk("rst_pc", 32'(bus_if.pc_out), 0);
    chk("rst_err", 32'(fetch_err), 0);
    bus_if.mem_done = 1'b1;
    bus_if.mem_data = DW'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_vld2", 32'(bus_if.instr_valid), 0);
    reset = 1'b1;
    run = r;
    bus_if.mem_done = 1'b0;
    bus_if.instr_ready = 1'b0;
    phase = 0;
    exp_pc = '0;
    exp_err = 1'b0;
    last_run = r;
    done_sent = 1'b0;
  endtask

  task automatic accept(input bit br, input logic [AW-1:0] tgt);
    k_ready = 1;
    k_br = br;
    k_tgt = tgt;
    k_tgt_en = 1'b1;
    step();
    k_ready = 0;
    step();
  endtask

  initial begin
    bus_if.mem_done = 1'b0;
    bus_if.mem_data = '0;
    bus_if.instr_ready = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.branch_target = '0;
    @(negedge clk);
    k_ready = 0;
    k_lat = 0;
    k_data = 'h0A5B;
    k_run = 1;
    do_reset(1'b1);
    run_until(2, 20);
    chk("t1_word", 32'(bus_if.instr_out), 'h0A5B);
    chk("t1_pc", 32'(bus_if.pc_out), 0);
    k_data = -1;
    repeat (5) step();
    accept(1'b0, '0);
    chk("t1_next", 32'(bus_if.mem_addr), 1);

    k_br = 1;
    k_tgt = 'h0100;
    k_tgt_en = 1'b1;
    run_until(2, 20);
    repeat (3) step();
    chk("t3_ignore", 32'(bus_if.pc_out), 1);
    accept(1'b1, 'h0100);
    chk("t3_addr", 32'(bus_if.mem_addr), 'h0100);
    run_until(2, 20);
    accept(1'b1, 'h1FFF);
    chk("t4_top", 32'(bus_if.mem_addr), 'h1FFF);
    run_until(2, 20);
    accept(1'b0, '0);
    chk("t4_wrap", 32'(bus_if.mem_addr), 0);

    k_run = -1;
    k_ready = -1;
    k_br = -1;
    k_lat = -1;
    k_tgt_en = 1'b0;
    repeat (2000) step();

    k_run = 1;
    k_ready = 0;
    run_until(2, 200);
    k_lat = 5;
    k_ready = 1;
    step();
    k_ready = 0;
    step();
    step();
    step();
    do_reset(1'b1);
    k_lat = 0;
    run_until(2, 20);
    chk("t6_pc", 32'(bus_if.pc_out), 0);

`ifdef FETCH_TIMEOUT_EN
    k_lat = 14;
    accept(1'b0, '0);
    run_until(2, 40);
    chk("t5_late", 32'(fetch_err), 0);
    k_lat = 999;
    accept(1'b0, '0);
    repeat (15) step();
    @(negedge clk);
    chk("t5_err", 32'(fetch_err), 1);
    chk("t5_rd", 32'(bus_if.mem_read), 0);
    bus_if.mem_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_stick", 32'(fetch_err), 1);
    chk("t5_vld", 32'(bus_if.instr_valid), 0);
`else
    k_lat = 40;
    accept(1'b0, '0);
    run_until(2, 60);
    chk("t5_noto", 32'(fetch_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
